// File: rtl/registro_universal_param.sv
// Parametrised universal shift register: hold, shift, rotate and load in either direction,
// plus a burst engine that runs a programmed number of shift/rotate steps with BUSY/DONE.
//
// state | meaning
// IDLE  | single-step per MODO/DIR each enabled cycle; START (shift/rotate only) arms a burst
// SHIFT | burst running, one latched-mode step per enabled cycle, counter counts down
// FIN   | one-cycle DONE pulse, no step, returns to IDLE
module registro_universal_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic [CNT_W-1:0] AMT,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             burstRot, burstRotNext;
  logic             burstDir, burstDirNext;
  logic [1:0]       stepMode;
  logic             stepDir;
  logic [WIDTH-1:0] qNext;
  logic             sOutNext;
  logic             busyNext, doneNext;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state    <= IDLE;
      cnt      <= '0;
      burstRot <= 1'b0;
      burstDir <= 1'b0;
      Q        <= '0;
      S_OUT    <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else if (ENB) begin
      state    <= stateNext;
      cnt      <= cntNext;
      burstRot <= burstRotNext;
      burstDir <= burstDirNext;
      Q        <= qNext;
      S_OUT    <= sOutNext;
      BUSY     <= busyNext;
      DONE     <= doneNext;
    end
  end

  // Sequencing: picks which step (if any) the datapath applies this cycle.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    burstRotNext = burstRot;
    burstDirNext = burstDir;
    stepMode     = 2'b11;
    stepDir      = DIR;
    case (state)
      IDLE: begin
        if (START && !MODO[1]) begin
          burstRotNext = MODO[0];
          burstDirNext = DIR;
          cntNext      = AMT;
          stateNext    = (AMT == '0) ? FIN : SHIFT;
        end else begin
          stepMode = MODO;
        end
      end
      SHIFT: begin
        stepMode = {1'b0, burstRot};
        stepDir  = burstDir;
        cntNext  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) stateNext = FIN;
      end
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: one step of the selected kind.
  always_comb begin
    qNext    = Q;
    sOutNext = S_OUT;
    case (stepMode)
      2'b00: begin
        if (!stepDir) begin
          qNext    = {Q[WIDTH-2:0], S_IN};
          sOutNext = Q[WIDTH-1];
        end else begin
          qNext    = {S_IN, Q[WIDTH-1:1]};
          sOutNext = Q[0];
        end
      end
      2'b01: begin
        if (!stepDir) begin
          qNext    = {Q[WIDTH-2:0], Q[WIDTH-1]};
          sOutNext = Q[WIDTH-1];
        end else begin
          qNext    = {Q[0], Q[WIDTH-1:1]};
          sOutNext = Q[0];
        end
      end
      2'b10:   qNext = D;
      default: ;
    endcase
  end

  assign busyNext = (stateNext == SHIFT);
  assign doneNext = (stateNext == FIN);

endmodule

// File: doc/registro_universal_param.md
Name: registro_universal_param

Overview:
- Parametrised N-bit universal shift register. Successor to the 4-bit per-bit mux-selector design.
- Supports hold, serial shift, rotate and parallel load in either direction.
- Adds a burst engine that performs a programmed number of shift/rotate steps autonomously, with BUSY/DONE handshake.
- Sits in the datapath as a general shift/serialise stage, driven by a controller FSM.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of burst amount/counter; max burst = 2^CNT_W-1.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_L  input  1  asynchronous, active-low reset.
- ENB  input  1  clock enable; 0 freezes all state (register, counter, FSM).
- MODO  input  2  00 serial shift, 01 rotate, 10 parallel load, 11 hold.
- DIR  input  1  0 = left (toward MSB), 1 = right (toward LSB).
- S_IN  input  1  serial input bit for MODO=00.
- D  input  WIDTH  parallel load data.
- START  input  1  request burst of AMT steps using current MODO/DIR.
- AMT  input  CNT_W  burst step count.
- Q  output  WIDTH  register contents.
- S_OUT  output  1  registered copy of last bit shifted/rotated out.
- BUSY  output  1  burst in progress.
- DONE  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async, RESET_L=0): Q=0, S_OUT=0, BUSY=0, DONE=0, counter=0, FSM=IDLE. Takes effect immediately, including mid-burst. First update occurs on the first CLK edge after release.
- Step definitions (one clock):
  - Left shift: Q<={Q[WIDTH-2:0],S_IN}, S_OUT<=Q[WIDTH-1].
  - Right shift: Q<={S_IN,Q[WIDTH-1:1]}, S_OUT<=Q[0].
  - Left rotate: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}, S_OUT<=Q[WIDTH-1].
  - Right rotate: Q<={Q[0],Q[WIDTH-1:1]}, S_OUT<=Q[0].
  - Load: Q<=D, S_OUT unchanged. Hold: no change.
- FSM states: IDLE, SHIFT, FIN.
- IDLE, ENB=1, START=0: apply one step per MODO/DIR every cycle (single-step mode).
- IDLE, ENB=1, START=1, MODO[1]=0:
  - Latch MODO[0], DIR and AMT; no step this cycle.
  - AMT=0: go to FIN.
  - AMT!=0: go to SHIFT with BUSY=1 from the next cycle.
- IDLE, START=1, MODO[1]=1: START ignored; normal load/hold step applies.
- SHIFT, ENB=1:
  - One step per cycle using the latched mode/dir. S_IN is sampled live each step.
  - Counter decrements; after the AMT-th step go to FIN.
  - External MODO, DIR, D, AMT and START are ignored.
- SHIFT, ENB=0: stall. Q, counter and state hold; BUSY stays 1.
- FIN: DONE=1, BUSY=0 for exactly one cycle. No step; START ignored. Next state IDLE. FIN advances only when ENB=1.
- Latency: a burst of AMT=n gives BUSY high for n enabled cycles; DONE asserts on the cycle after the last step.
- ENB=0 in IDLE: everything holds, START ignored.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset/load: WIDTH=8, RESET_L=0 -> Q=00, S_OUT=0, BUSY=0. Release, MODO=10, D=A5 -> Q=A5 after 1 edge. MODO=11 for 3 cycles -> Q stays A5.
- Single-step shift: Q=81, MODO=00, DIR=0, S_IN=1 -> Q=03, S_OUT=1. Then DIR=1, S_IN=0 -> Q=01, S_OUT=1.
- Burst rotate: Q=81, MODO=01, DIR=1, AMT=3, START pulse -> BUSY high 3 cycles, Q sequence C0,60,30. DONE pulses once on the following cycle, then IDLE.
- Burst with stall: AMT=4 serial left, S_IN=1, Q=00. ENB=0 for 2 cycles after step 2 -> Q holds 03 during the stall. Final Q=0F after step 4; DONE after 4 enabled steps.
- Edge cases:
  - AMT=0 START -> DONE next cycle, Q unchanged, BUSY never 1.
  - START with MODO=10 -> plain load, no BUSY.
  - MODO/D changes during BUSY -> no effect on the burst.
- Reset mid-burst: assert RESET_L=0 at step 2 of an AMT=5 burst -> Q, BUSY, DONE and S_OUT go to 0 immediately, without waiting for a CLK edge. After release, no DONE pulse occurs.
